tx_frame_ctrl: RTL and testbench
================================

Name: tx_frame_ctrl

Overview:
- Controller directly upstream and downstream of the team's synchronous-write/synchronous-read 2-port frame RAM.
- Accepts transmit bytes from the host and writes them into the RAM write port.
- Holds each byte back until the host commits the frame (xsnd) or discards it (xabort).
- Streams committed bytes out of the RAM read port to the transmitter over a valid/ready interface, hiding the RAM's 1-cycle read latency at full throughput.

Parameters:
- W, 8: data width in bits.
- D, 128: RAM depth in entries; must be a power of two.
- DW, $clog2(D): address width; localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- xdata  input  W  host byte to write.
- xwr  input  1  write strobe; one byte per cycle when high.
- xsnd  input  1  commit all bytes written since the last commit or abort.
- xabort  input  1  discard all uncommitted bytes.
- wr_full  output  1  RAM holds D bytes (committed + uncommitted + unread).
- overflow  output  1  sticky; a write was attempted while wr_full.
- dout  output  W  byte to transmitter.
- dout_valid  output  1  dout holds a committed byte.
- dout_ready  input  1  transmitter accepts dout this cycle.
- rd_empty  output  1  no committed unread byte in RAM or output stage.
- mem_we  output  1  to RAM write enable.
- mem_waddr  output  DW  to RAM write address.
- mem_wdata  output  W  to RAM write data.
- mem_raddr  output  DW  to RAM read address.
- mem_rdata  input  W  from RAM; valid the cycle after mem_raddr is sampled.

Behaviour:
- Pointers wptr, cptr and rptr are each DW+1 bits and wrap modulo 2D.
  - wptr: next write location.
  - cptr: end of the committed region.
  - rptr: next RAM read.
- Occupancy is wptr - rptr; wr_full = (occupancy == D).
- Write side:
  - mem_we = xwr & ~wr_full & ~xabort (combinational).
  - mem_waddr = wptr[DW-1:0]; mem_wdata = xdata.
  - wptr increments on mem_we.
- Overflow: xwr while wr_full sets overflow; the byte is dropped and wptr is unchanged. overflow clears only on xabort or rst.
- Commit: xsnd (without xabort) loads cptr with the post-increment wptr. A byte written in the same cycle as xsnd belongs to the committed frame. A commit with no new bytes has no effect.
- Abort:
  - xabort loads wptr with cptr, discarding uncommitted bytes.
  - xabort wins over a simultaneous xwr (byte discarded) and over a simultaneous xsnd (no commit).
  - Committed data is never affected.
- Read side:
  - The output stage is a 2-entry buffer (dout register + skid entry), plus an in-flight flag for the outstanding RAM read.
  - A RAM read issues (mem_raddr = rptr[DW-1:0], rptr++) when rptr != cptr and (buffered entries + in-flight) < 2, counting the entry being popped this cycle as freed.
  - Returning mem_rdata loads the dout register if it is empty, otherwise the skid entry.
  - A pop (dout_valid & dout_ready) advances the skid entry into dout.
  - dout and dout_valid are registered.
  - dout holds stable while dout_valid & ~dout_ready.
- Throughput: one byte per cycle sustained while dout_ready stays high.
- Latency: xsnd sampled at edge E; first mem_raddr at edge E+1; dout_valid high after edge E+2.
- rd_empty = (rptr == cptr) & no read in flight & output buffer empty.
- A read slot is freed at the RAM only when rptr passes it, so wr_full already accounts for bytes sitting in the output stage. Output ordering is strictly FIFO.
- Reset (asynchronous, any time, including mid-frame or mid-read):
  - All pointers cleared; in-flight read discarded.
  - dout = 0, dout_valid = 0, overflow = 0, wr_full = 0, rd_empty = 1.
  - Combinational memory outputs follow the reset pointers: mem_waddr = 0, mem_raddr = 0, and mem_we = 0 whenever xwr is low.

Test Plan:
- D=8. After reset, write 0x11, 0x22, 0x33 with xsnd on the third write, dout_ready=1 → dout shows 0x11, 0x22, 0x33 on consecutive cycles, first byte 2 cycles after the xsnd edge; rd_empty returns to 1.
- Write 0xA0..0xA3, no xsnd, then xabort; write 0xB0 with xsnd → only 0xB0 is output; dout_valid never shows 0xA*.
- D=8. Write 9 bytes 0x00..0x08 with no reads → wr_full asserts after the 8th byte; 0x08 is dropped; overflow=1. xsnd, then drain → exactly 0x00..0x07 out. xabort then clears overflow.
- Commit 4 bytes with dout_ready low for 5 cycles then high → dout holds the first byte stable while stalled; all 4 bytes emerge in order with no duplicates or gaps.
- Fill and drain 20 bytes across the 8-deep wrap with xwr and dout_ready both toggling randomly → output sequence equals the committed input sequence.
- Assert rst while a read is in flight and dout_valid=1 → all outputs take their reset values immediately; the next committed frame 0x5A is output correctly.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// Transmit frame controller: stages host bytes in a 2-port frame RAM, releases them on commit,
// and streams committed bytes to the transmitter through a 2-entry registered output stage.
module tx_frame_ctrl #(
    parameter int W = 8,
    parameter int D = 128,
    localparam int DW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  xdata,
    input  logic          xwr,
    input  logic          xsnd,
    input  logic          xabort,
    output logic          wr_full,
    output logic          overflow,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          rd_empty,
    output logic          mem_we,
    output logic [DW-1:0] mem_waddr,
    output logic [W-1:0]  mem_wdata,
    output logic [DW-1:0] mem_raddr,
    input  logic [W-1:0]  mem_rdata
);

    logic [DW:0]  wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
    logic [DW:0]  wptr_inc, occupancy;
    logic         overflow_q, overflow_d;
    logic [W-1:0] dout_q, dout_d, skid_q, skid_d;
    logic         dout_valid_q, dout_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         inflight_q, inflight_d;
    logic         pop, issue;
    logic [1:0]   stage_cnt;

    // Occupancy spans uncommitted, committed and staged bytes: a RAM slot frees only when rptr passes it.
    assign occupancy = wptr_q - rptr_q;
    assign wr_full   = (occupancy == (DW+1)'(D));
    assign mem_we    = xwr & ~wr_full & ~xabort;
    assign mem_waddr = wptr_q[DW-1:0];
    assign mem_wdata = xdata;
    assign wptr_inc  = wptr_q + {{DW{1'b0}}, mem_we};

    assign pop       = dout_valid_q & dout_ready;
    assign stage_cnt = {1'b0, dout_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q} - {1'b0, pop};
    assign issue     = (rptr_q != cptr_q) && (stage_cnt < 2'd2);
    assign mem_raddr = rptr_q[DW-1:0];

    assign rd_empty   = (rptr_q == cptr_q) & ~inflight_q & ~dout_valid_q & ~skid_valid_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;

    always_comb begin
        wptr_d     = xabort ? cptr_q : wptr_inc;
        cptr_d     = (xsnd & ~xabort) ? wptr_inc : cptr_q;
        rptr_d     = rptr_q + {{DW{1'b0}}, issue};
        overflow_d = xabort ? 1'b0 : (overflow_q | (xwr & wr_full));
        inflight_d = issue;
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (pop) begin
            dout_valid_d = skid_valid_q;
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
                dout_d = skid_q;
            end
        end
        // Returning RAM data fills the oldest free slot so ordering stays FIFO.
        if (inflight_q) begin
            if (!dout_valid_d) begin
                dout_d       = mem_rdata;
                dout_valid_d = 1'b1;
            end else begin
                skid_d       = mem_rdata;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            cptr_q       <= '0;
            rptr_q       <= '0;
            overflow_q   <= 1'b0;
            inflight_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            cptr_q       <= cptr_d;
            rptr_q       <= rptr_d;
            overflow_q   <= overflow_d;
            inflight_q   <= inflight_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl with D=8: directed frames, scoreboard queue checked by a pop monitor.
module tb_tx_frame_ctrl;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  xdata;
    logic          xwr, xsnd, xabort;
    logic          wr_full, overflow;
    logic [W-1:0]  dout;
    logic          dout_valid, dout_ready, rd_empty;
    logic          mem_we;
    logic [DW-1:0] mem_waddr, mem_raddr;
    logic [W-1:0]  mem_wdata, mem_rdata;

    logic [W-1:0]  ram [D];
    logic [W-1:0]  exp_q [$];
    int            checks = 0;
    int            passed = 0;
    logic          rand_ready = 1'b0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_dout = '0;

    tx_frame_ctrl #(.W(W), .D(D)) dut (
        .clk(clk), .rst(rst), .xdata(xdata), .xwr(xwr), .xsnd(xsnd), .xabort(xabort),
        .wr_full(wr_full), .overflow(overflow), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .rd_empty(rd_empty), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-write / synchronous-read frame RAM
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops expected bytes on every accepted transfer and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", dout_valid, 1);
                check("stall_data", dout, prev_dout);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pop: got 0x%0h expected no output", dout);
                end else begin
                    check("dout", dout, exp_q.pop_front());
                end
            end
            prev_stall = dout_valid & ~dout_ready;
            prev_dout  = dout;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 dout_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic wr, logic [W-1:0] d, logic snd, logic ab);
        xwr = wr; xdata = d; xsnd = snd; xabort = ab;
        tick();
        xwr = 1'b0; xsnd = 1'b0; xabort = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || !rd_empty) && n < 300) begin
            tick();
            n++;
        end
        check(name, {31'd0, (exp_q.size() == 0) && rd_empty}, 1);
    endtask

    initial begin
        rst = 1'b1; xdata = '0; xwr = 1'b0; xsnd = 1'b0; xabort = 1'b0; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_rd_empty", rd_empty, 1);
        check("rst_wr_full", wr_full, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Basic frame and latency from the commit edge
        dout_ready = 1'b1;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 1, 0);
        check("lat_e0_valid", dout_valid, 0);
        check("lat_e0_not_empty", rd_empty, 0);
        tick();
        check("lat_e1_valid", dout_valid, 0);
        tick();
        check("lat_e2_valid", dout_valid, 1);
        check("lat_e2_data", dout, 8'h11);
        tick();
        check("seq_b2", dout, 8'h22);
        tick();
        check("seq_b3", dout, 8'h33);
        wait_drain("drain_basic");

        // Abort discards uncommitted bytes
        exp_q.push_back(8'hB0);
        for (int i = 0; i < 4; i++) drive(1, 8'hA0 + 8'(i), 0, 0);
        drive(0, 8'h00, 0, 1);
        check("abort_rd_empty", rd_empty, 1);
        drive(1, 8'hB0, 1, 0);
        wait_drain("drain_abort");

        // Fill to full, drop the ninth byte, then drain
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(1, 8'(i), 0, 0);
        check("full_after_8", wr_full, 1);
        check("no_ovf_yet", overflow, 0);
        xwr = 1'b1; xdata = 8'h08;
        #1;
        check("drop_we", mem_we, 0);
        tick();
        xwr = 1'b0;
        check("ovf_set", overflow, 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        drive(0, 8'h00, 1, 0);
        dout_ready = 1'b1;
        wait_drain("drain_full");
        check("full_clear", wr_full, 0);
        check("ovf_sticky", overflow, 1);
        drive(0, 8'h00, 0, 1);
        check("ovf_cleared", overflow, 0);

        // Stalled output holds the first byte
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h41 + 8'(i));
        for (int i = 0; i < 4; i++) drive(1, 8'h41 + 8'(i), (i == 3), 0);
        repeat (5) tick();
        check("stall_first_valid", dout_valid, 1);
        check("stall_first_data", dout, 8'h41);
        dout_ready = 1'b1;
        wait_drain("drain_stall");

        // Wrap with random gaps and random back-pressure
        rand_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            int n = 0;
            while (exp_q.size() > 4 && n < 300) begin
                tick();
                n++;
            end
            check("rand_space", {31'd0, exp_q.size() <= 4}, 1);
            for (int i = 0; i < 4; i++) begin
                logic [W-1:0] v;
                v = 8'hC0 + 8'(f * 4 + i);
                repeat ($urandom_range(0, 2)) tick();
                exp_q.push_back(v);
                drive(1, v, (i == 3), 0);
            end
        end
        rand_ready = 1'b0;
        tick();
        dout_ready = 1'b1;
        wait_drain("drain_rand");

        // Asynchronous reset with a read in flight and dout valid
        exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
        drive(1, 8'h61, 0, 0);
        drive(1, 8'h62, 0, 0);
        drive(1, 8'h63, 1, 0);
        tick();
        tick();
        check("pre_rst_valid", dout_valid, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_dout_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_rd_empty", rd_empty, 1);
        check("arst_wr_full", wr_full, 0);
        check("arst_overflow", overflow, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_waddr", mem_waddr, 0);
        check("arst_raddr", mem_raddr, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        exp_q.push_back(8'h5A);
        drive(1, 8'h5A, 1, 0);
        wait_drain("drain_post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", passed, checks);
        $fatal(1);
    end

endmodule
